// File: rtl/spi_pkg.sv
// spi_pkg: shared constants, FSM encodings and mode helpers for the SPI slave.
package spi_pkg;
    localparam int BYTE_W = 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb;
    } spi_mode_t;

    function automatic logic first_bit(input logic [BYTE_W-1:0] b, input logic lsb);
        return lsb ? b[0] : b[BYTE_W-1];
    endfunction
endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchronizer with a per-bit reset level.
module spi_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [W-1:0] init,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            meta <= init;
            q    <= init;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/spi_slave_io.sv
// spi_slave_io: oversampled SPI slave, all four modes, MSB/LSB first,
// continuous multi-byte transfers under one slave select.
module spi_slave_io
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              spi_en,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfirst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_access,
    input  logic              rx_wait,
    output logic              rx_overrun,
    output logic [1:0]        spi_state
);
    logic [2:0]        s;
    logic              ss_s, sclk_s, mosi_s;
    logic              ss_d, sclk_d;
    logic [1:0]        state;
    logic [2:0]        cnt;
    logic [BYTE_W-1:0] tx_sr, rx_sr;
    logic              fresh;
    spi_mode_t         mode_q, mode;
    logic              rise, fall, sample_edge, shift_edge, ss_fall;
    logic [BYTE_W-1:0] load_byte, tx_next, rx_next;

    spi_sync #(.W(3)) u_sync (
        .clk   (clk),
        .nreset(nreset),
        .init  ({1'b1, cpol, 1'b0}),
        .d     ({ss, sclk, mosi}),
        .q     (s)
    );

    assign ss_s      = s[2];
    assign sclk_s    = s[1];
    assign mosi_s    = s[0];
    assign spi_state = state;

    // Mode pins follow live inputs until SHIFT, then stay frozen for the transfer.
    always_comb begin
        mode        = state == ST_SHIFT ? mode_q : spi_mode_t'({cpol, cpha, lsbfirst});
        rise        = sclk_s & ~sclk_d;
        fall        = ~sclk_s & sclk_d;
        sample_edge = mode.cpol == mode.cpha ? rise : fall;
        shift_edge  = mode.cpol == mode.cpha ? fall : rise;
        ss_fall     = ss_d & ~ss_s;
        load_byte   = tx_valid ? tx_data : '0;
        tx_next     = mode.lsb ? {1'b0, tx_sr[BYTE_W-1:1]} : {tx_sr[BYTE_W-2:0], 1'b0};
        rx_next     = mode.lsb ? {mosi_s, rx_sr[BYTE_W-1:1]} : {rx_sr[BYTE_W-2:0], mosi_s};
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state      <= ST_IDLE;
            ss_d       <= 1'b1;
            sclk_d     <= cpol;
            cnt        <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            fresh      <= 1'b0;
            mode_q     <= '0;
            miso       <= 1'b0;
            tx_ready   <= 1'b0;
            rx_data    <= '0;
            rx_access  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            ss_d       <= ss_s;
            sclk_d     <= sclk_s;
            tx_ready   <= 1'b0;
            rx_access  <= 1'b0;
            rx_overrun <= 1'b0;
            if (state != ST_SHIFT)
                mode_q <= mode;
            if (!spi_en || (state == ST_SHIFT && ss_s) || state == 2'd3) begin
                state <= ST_IDLE;
                cnt   <= '0;
                miso  <= 1'b0;
            end else if (state == ST_IDLE) begin
                cnt  <= '0;
                miso <= 1'b0;
                if (ss_fall)
                    state <= ST_LOAD;
            end else if (state == ST_LOAD) begin
                tx_sr    <= load_byte;
                tx_ready <= tx_valid;
                miso     <= first_bit(load_byte, mode.lsb);
                fresh    <= mode.cpha;
                cnt      <= '0;
                rx_sr    <= '0;
                state    <= ST_SHIFT;
            end else if (sample_edge) begin
                rx_sr <= rx_next;
                cnt   <= cnt + 3'd1;
                // Byte boundary: hand the byte over and stage the next tx byte;
                // the following shift edge presents its first bit unshifted.
                if (cnt == 3'd7) begin
                    if (rx_wait)
                        rx_overrun <= 1'b1;
                    else begin
                        rx_data   <= rx_next;
                        rx_access <= 1'b1;
                    end
                    tx_sr    <= load_byte;
                    tx_ready <= tx_valid;
                    fresh    <= 1'b1;
                end
            end else if (shift_edge) begin
                if (fresh) begin
                    miso  <= first_bit(tx_sr, mode.lsb);
                    fresh <= 1'b0;
                end else begin
                    tx_sr <= tx_next;
                    miso  <= first_bit(tx_next, mode.lsb);
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_io.sv
// tb_spi_slave_io: SPI master model driving directed bytes; a monitor pops
// expected rx events from a scoreboard queue whenever the DUT pulses.
module tb_spi_slave_io;
    import spi_pkg::*;

    typedef struct {
        logic       ovr;
        logic [7:0] d;
    } ev_t;

    logic       clk = 0, nreset = 0, spi_en = 1;
    logic       cpol = 0, cpha = 0, lsbfirst = 0;
    logic       sclk = 0, mosi = 0, ss = 1;
    logic       miso, tx_ready, rx_access, rx_overrun, tx_valid = 0, rx_wait = 0;
    logic [7:0] tx_data = 0, rx_data, got;
    logic [1:0] spi_state;
    int         checks = 0, failures = 0, txr_cnt = 0, t0;
    ev_t        exp_q[$];
    logic [7:0] feed[$];

    spi_slave_io dut (
        .clk(clk), .nreset(nreset), .spi_en(spi_en), .cpol(cpol), .cpha(cpha),
        .lsbfirst(lsbfirst), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_access(rx_access), .rx_wait(rx_wait),
        .rx_overrun(rx_overrun), .spi_state(spi_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_h();
        repeat (8) @(negedge clk);
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic lsb);
        @(negedge clk);
        cpol = pol; cpha = pha; lsbfirst = lsb; sclk = pol;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_low();
        @(negedge clk);
        ss = 0;
        wait_h(); wait_h();
    endtask

    task automatic ss_high();
        wait_h();
        ss = 1;
        wait_h(); wait_h();
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        int b;
        mi = 0;
        for (int i = 0; i < n; i++) begin
            b = lsbfirst ? i : 7 - i;
            if (!cpha) begin
                mosi = mo[b]; wait_h();
                sclk = ~cpol; mi[b] = miso; wait_h();
                sclk = cpol;
            end else begin
                sclk = ~cpol; mosi = mo[b]; wait_h();
                sclk = cpol; mi[b] = miso; wait_h();
            end
        end
    endtask

    task automatic one_byte(input string name, input logic [7:0] mo, input logic [7:0] tx,
                            input logic [7:0] mexp);
        feed.push_back(tx);
        exp_q.push_back('{1'b0, mo});
        t0 = txr_cnt;
        ss_low();
        spi_bits(mo, 8, got);
        ss_high();
        chk({name, "_master_rx"}, got, mexp);
        chk({name, "_tx_ready_cnt"}, txr_cnt - t0, 1);
    endtask

    initial forever begin
        @(negedge clk);
        if (tx_ready && feed.size() > 0) void'(feed.pop_front());
        tx_valid = feed.size() > 0;
        tx_data  = tx_valid ? feed[0] : 8'h00;
    end

    ev_t ev;
    initial forever begin
        @(posedge clk);
        #1;
        if (tx_ready) txr_cnt++;
        if (rx_access || rx_overrun) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx_unexpected access=%0b overrun=%0b data=%0h expected=none",
                         rx_access, rx_overrun, rx_data);
            end else begin
                ev = exp_q.pop_front();
                chk("rx_overrun_flag", rx_overrun, ev.ovr);
                chk("rx_access_flag", rx_access, !ev.ovr);
                chk("rx_data", rx_data, ev.d);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_access", rx_access, 0);
        chk("rst_rx_overrun", rx_overrun, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_state", spi_state, ST_IDLE);
        nreset = 1;
        repeat (4) @(negedge clk);

        set_mode(0, 0, 0);
        one_byte("mode0", 8'hA5, 8'h3C, 8'h3C);
        chk("idle_miso", miso, 0);
        set_mode(0, 1, 0);
        one_byte("mode1", 8'h81, 8'h81, 8'h81);
        set_mode(1, 0, 0);
        one_byte("mode2", 8'h81, 8'h81, 8'h81);
        set_mode(1, 1, 0);
        one_byte("mode3", 8'h81, 8'h81, 8'h81);
        set_mode(0, 0, 1);
        one_byte("lsb0", 8'h81, 8'h81, 8'h81);
        set_mode(1, 1, 1);
        one_byte("lsb3", 8'h12, 8'hC4, 8'hC4);

        set_mode(0, 0, 0);
        feed.push_back(8'h10); feed.push_back(8'h20); feed.push_back(8'h30);
        for (int i = 1; i <= 3; i++) exp_q.push_back('{1'b0, 8'(i)});
        t0 = txr_cnt;
        ss_low();
        spi_bits(8'h01, 8, got); chk("burst_b1", got, 8'h10);
        spi_bits(8'h02, 8, got); chk("burst_b2", got, 8'h20);
        spi_bits(8'h03, 8, got); chk("burst_b3", got, 8'h30);
        ss_high();
        chk("burst_tx_ready_cnt", txr_cnt - t0, 3);

        set_mode(0, 1, 0);
        feed.push_back(8'hA1); feed.push_back(8'hB2);
        exp_q.push_back('{1'b0, 8'h11});
        exp_q.push_back('{1'b1, 8'h11});
        ss_low();
        spi_bits(8'h11, 8, got); chk("ovr_b1", got, 8'hA1);
        rx_wait = 1;
        spi_bits(8'h22, 8, got); chk("ovr_b2", got, 8'hB2);
        ss_high();
        rx_wait = 0;
        chk("ovr_rx_data_held", rx_data, 8'h11);

        set_mode(0, 0, 0);
        ss_low();
        spi_bits(8'hFF, 5, got);
        ss_high();
        chk("partial_state", spi_state, ST_IDLE);
        one_byte("after_partial", 8'h5A, 8'h6B, 8'h6B);

        exp_q.push_back('{1'b0, 8'h77});
        t0 = txr_cnt;
        ss_low();
        spi_bits(8'h77, 8, got);
        ss_high();
        chk("novalid_master_rx", got, 8'h00);
        chk("novalid_tx_ready_cnt", txr_cnt - t0, 0);

        t0 = txr_cnt;
        ss_low();
        spi_bits(8'hC3, 4, got);
        nreset = 0; ss = 1; sclk = cpol;
        repeat (2) @(negedge clk);
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_state", spi_state, ST_IDLE);
        chk("mid_rst_tx_ready", tx_ready, 0);
        chk("mid_rst_rx_access", rx_access, 0);
        nreset = 1;
        wait_h(); wait_h();
        chk("mid_rst_no_tx_ready", txr_cnt - t0, 0);
        chk("rx_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave_io.md
SPI_SLAVE_IO -- requirements
Module: spi_slave_io

Interface
REQ-001 Parameters: none; byte width fixed at 8, mode selected by input pins.
REQ-002 Port list:
- clk  input  1  core clock; sole clock; all state on rising edge
- nreset  input  1  synchronous active-low reset, sampled on rising clk
- spi_en  input  1  block enable; low forces IDLE
- cpol  input  1  SPI clock polarity
- cpha  input  1  SPI clock phase
- lsbfirst  input  1  1 = LSB shifted first, 0 = MSB first
- sclk  input  1  SPI clock from master, asynchronous
- mosi  input  1  serial data from master, asynchronous
- ss  input  1  slave select, active low, asynchronous
- miso  output  1  serial data to master, registered
- tx_data  input  8  next byte to transmit
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  one-cycle pulse: tx_data consumed
- rx_data  output  8  last complete received byte, held until next byte
- rx_access  output  1  one-cycle pulse: rx_data updated
- rx_wait  input  1  core cannot accept a byte
- rx_overrun  output  1  one-cycle pulse: byte dropped because rx_wait high
- spi_state  output  2  FSM state encoding

Function
REQ-003 sclk, mosi and ss SHALL each pass through a 2-flop synchronizer; all logic uses synchronized copies only.
REQ-004 Edge detect on synchronized sclk (3rd flop); sample edge = rising when cpol==cpha, falling otherwise; shift edge = opposite edge.
REQ-005 Functional only for clk >= 8x sclk frequency; no behaviour defined below that ratio.
REQ-006 FSM states: IDLE=0, LOAD=1, SHIFT=2.
REQ-007 IDLE -> LOAD on synchronized ss falling while spi_en high; LOAD -> SHIFT after exactly one cycle; SHIFT -> IDLE on synchronized ss high or spi_en low.
REQ-008 LOAD: if tx_valid, copy tx_data into tx shift register and pulse tx_ready; else load 0x00 without pulsing tx_ready; bit counter cleared to 0.
REQ-009 miso SHALL present the first tx bit (bit 7, or bit 0 if lsbfirst) by end of LOAD; for cpha=0 this bit is already valid before the first sample edge.
REQ-010 Each sample edge in SHIFT: shift synchronized mosi into rx shift register (insert at LSB, or at MSB when lsbfirst), increment 3-bit bit counter (wraps 7->0).
REQ-011 Each shift edge in SHIFT: advance tx shift register and update miso, except the first shift edge when cpha=1, which leaves the first bit in place.
REQ-012 On the sample edge where counter wraps 7->0: if rx_wait low, load rx_data and pulse rx_access next cycle; if rx_wait high, keep rx_data, pulse rx_overrun next cycle.
REQ-013 Same wrap cycle: reload tx shift register per REQ-008 rules (tx_ready pulse or 0x00); continuous multi-byte transfers without ss deassertion SHALL work.
REQ-014 ss deassertion mid-byte: partial byte discarded, no rx_access, counter cleared, state IDLE next cycle.
REQ-015 miso SHALL be 0 in IDLE.
REQ-016 Mode inputs (cpol, cpha, lsbfirst) are only sampled in IDLE/LOAD; changes during SHIFT SHALL be ignored until next IDLE.

Reset
REQ-017 nreset low on a rising clk: state IDLE, miso 0, tx_ready 0, rx_access 0, rx_overrun 0, rx_data 0x00, bit counter 0, shift registers 0, synchronizers to idle level (ss 1, sclk = cpol, mosi 0).
REQ-018 Reset asserted mid-transfer SHALL abandon the byte without any rx_access/tx_ready pulse.

Structure
REQ-019 State encodings and byte-width constant SHALL live in shared package spi_pkg.
REQ-020 Synchronizer SHALL be one reusable sub-module spi_sync (2-flop, parameterized width), instantiated once for width 3.

Verification
REQ-021 Mode 0, MSB-first, master sends 0xA5 while tx_data=0x3C valid -> one rx_access with rx_data=0xA5, master receives 0x3C, one tx_ready.
REQ-022 Modes 1, 2, 3 and lsbfirst=1 each, byte 0x81 both directions -> identical data received both ends.
REQ-023 Three back-to-back bytes 0x01,0x02,0x03 under one ss low -> three rx_access pulses in order, three tx_ready pulses.
REQ-024 rx_wait=1 during second byte wrap -> rx_overrun pulse, rx_data remains first byte.
REQ-025 ss raised after 5 bits -> no rx_access, state IDLE; next full byte 0x5A received correctly.
REQ-026 tx_valid=0 at LOAD -> master receives 0x00, no tx_ready; nreset pulse mid-byte -> all outputs at reset values.
